// File: rtl/odd_shift_rotate_unit_pkg.sv
// Shared types for the odd-pipe quadword shift/rotate unit: opcode enum and count-field geometry.
// Count fields are big-endian bits 29..31 / 27..31 of the count word, i.e. its least significant bits.
package odd_shift_rotate_unit_pkg;

  typedef enum logic [3:0] {
    SR_NOP  = 4'd0,
    SHLQBI  = 4'd1,
    SHLQBII = 4'd2,
    SHLQBY  = 4'd3,
    SHLQBYI = 4'd4,
    ROTQBI  = 4'd5,
    ROTQBII = 4'd6,
    ROTQBY  = 4'd7,
    ROTQBYI = 4'd8
  } sr_op_t;

  localparam int BIT_CNT_W  = 3;
  localparam int BYTE_CNT_W = 5;
  localparam int I7_W       = 7;

  function automatic logic is_imm_form(input sr_op_t op);
    return (op == SHLQBII) || (op == SHLQBYI) || (op == ROTQBII) || (op == ROTQBYI);
  endfunction

endpackage

// File: rtl/odd_shift_rotate_unit_sr_compute.sv
// Combinational operand-to-result logic for quadword bit/byte shifts and rotates.
// Zero latency; no flow control, the caller registers the result.
module sr_compute
  import odd_shift_rotate_unit_pkg::*;
#(
  parameter int DATA_W = 128
) (
  input  sr_op_t            op,
  input  logic [DATA_W-1:0] ra,
  input  logic [DATA_W-1:0] rb,
  input  logic [I7_W-1:0]   i7,
  output logic [DATA_W-1:0] rt,
  output logic              wr_en
);

  localparam int AW    = $clog2(DATA_W);
  localparam int BYTES = DATA_W / 8;

  logic [BIT_CNT_W-1:0]  bit_cnt;
  logic [BYTE_CNT_W-1:0] byte_cnt;
  logic [AW-1:0]         bit_amt;
  logic [AW-1:0]         byte_amt;
  logic                  byte_ovf;
  logic [2*DATA_W-1:0]   rot_bit;
  logic [2*DATA_W-1:0]   rot_byte;
  logic                  unused_bits;

  assign bit_cnt  = is_imm_form(op) ? i7[BIT_CNT_W-1:0]  : rb[BIT_CNT_W-1:0];
  assign byte_cnt = is_imm_form(op) ? i7[BYTE_CNT_W-1:0] : rb[BYTE_CNT_W-1:0];
  assign bit_amt  = AW'(bit_cnt);
  // Truncating count*8 to AW bits is exactly (count mod BYTES)*8, which the byte rotate wants.
  assign byte_amt = AW'({byte_cnt, 3'b000});
  assign byte_ovf = int'(byte_cnt) >= BYTES;

  // Upper half of the doubled operand shifted left is the left rotate.
  assign rot_bit  = {ra, ra} << bit_amt;
  assign rot_byte = {ra, ra} << byte_amt;

  assign unused_bits = ^{rb[DATA_W-1:BYTE_CNT_W], i7[I7_W-1:BYTE_CNT_W],
                         rot_bit[DATA_W-1:0], rot_byte[DATA_W-1:0]};

  always_comb begin
    rt    = '0;
    wr_en = 1'b1;
    case (op)
      SHLQBI, SHLQBII: rt = ra << bit_amt;
      SHLQBY, SHLQBYI: rt = byte_ovf ? '0 : (ra << byte_amt);
      ROTQBI, ROTQBII: rt = rot_bit[2*DATA_W-1 -: DATA_W];
      ROTQBY, ROTQBYI: rt = rot_byte[2*DATA_W-1 -: DATA_W];
      default:         wr_en = 1'b0;
    endcase
  end

endmodule

// File: rtl/odd_shift_rotate_unit.sv
// Odd-pipe shift/rotate unit: result computed at entry, then carried through STAGES registers.
// Latency STAGES cycles plus stall cycles; no backpressure, stall freezes every stage, flush kills all.
module odd_shift_rotate_unit
  import odd_shift_rotate_unit_pkg::*;
#(
  parameter int DATA_W = 128,
  parameter int STAGES = 4,
  parameter int ADDR_W = 7
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  input  sr_op_t                   in_op,
  input  logic [DATA_W-1:0]        ra_input,
  input  logic [DATA_W-1:0]        rb_input,
  input  logic [I7_W-1:0]          I7_input,
  input  logic [ADDR_W-1:0]        rt_address_input,
  input  logic                     stall,
  input  logic                     flush,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        rt_value_output,
  output logic [ADDR_W-1:0]        rt_address_output,
  output logic                     wrt_en_output,
  output logic [STAGES-1:0]        stage_valid,
  output logic [STAGES*ADDR_W-1:0] stage_rt_address
);

  typedef struct packed {
    logic              vld;
    logic              wr_en;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] dat;
  } stage_t;

  stage_t            entry;
  stage_t            pipe_q [STAGES];
  logic [DATA_W-1:0] entry_dat;
  logic              entry_wr_en;

  sr_compute #(.DATA_W(DATA_W)) u_compute (
    .op    (in_op),
    .ra    (ra_input),
    .rb    (rb_input),
    .i7    (I7_input),
    .rt    (entry_dat),
    .wr_en (entry_wr_en)
  );

  assign entry = {in_valid, in_valid & entry_wr_en, rt_address_input, entry_dat};

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    stage_t d;

    if (k == 0) begin : g_head
      assign d = entry;
    end else begin : g_tail
      assign d = pipe_q[k-1];
    end

    // Flush only clears the qualifiers; stale data behind a cleared valid is harmless.
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        pipe_q[k] <= '0;
      end else if (flush) begin
        pipe_q[k].vld   <= 1'b0;
        pipe_q[k].wr_en <= 1'b0;
      end else if (!stall) begin
        pipe_q[k] <= d;
      end
    end

    assign stage_valid[k]                       = pipe_q[k].vld;
    assign stage_rt_address[k*ADDR_W +: ADDR_W] = pipe_q[k].addr;
  end

  assign out_valid         = pipe_q[STAGES-1].vld;
  assign wrt_en_output     = pipe_q[STAGES-1].wr_en;
  assign rt_value_output   = pipe_q[STAGES-1].dat;
  assign rt_address_output = pipe_q[STAGES-1].addr;

endmodule

// File: tb/tb_odd_shift_rotate_unit.sv
// Bench for odd_shift_rotate_unit: directed vectors, a queue-based reference model and literal pins.
module tb_odd_shift_rotate_unit;
  import odd_shift_rotate_unit_pkg::*;

  localparam int DW = 128;
  localparam int ST = 4;
  localparam int AW = 7;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic          in_valid = 1'b0;
  sr_op_t        in_op    = SR_NOP;
  logic [DW-1:0] ra       = '0;
  logic [DW-1:0] rb       = '0;
  logic [6:0]    i7       = '0;
  logic [AW-1:0] rt_addr  = '0;
  logic          stall    = 1'b0;
  logic          flush    = 1'b0;

  logic             out_valid, wrt_en_output;
  logic [DW-1:0]    rt_value_output;
  logic [AW-1:0]    rt_address_output;
  logic [ST-1:0]    stage_valid;
  logic [ST*AW-1:0] stage_rt_address;

  // Narrow, single-stage instance
  logic          in_valid1 = 1'b0;
  sr_op_t        op1       = SR_NOP;
  logic [63:0]   ra1       = '0;
  logic [63:0]   rb1       = '0;
  logic          o1_valid, o1_wen, o1_sv;
  logic [63:0]   o1_value;
  logic [AW-1:0] o1_addr, o1_saddr;

  odd_shift_rotate_unit #(.DATA_W(DW), .STAGES(ST), .ADDR_W(AW)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_op(in_op),
    .ra_input(ra), .rb_input(rb), .I7_input(i7), .rt_address_input(rt_addr),
    .stall(stall), .flush(flush), .out_valid(out_valid),
    .rt_value_output(rt_value_output), .rt_address_output(rt_address_output),
    .wrt_en_output(wrt_en_output), .stage_valid(stage_valid),
    .stage_rt_address(stage_rt_address)
  );

  odd_shift_rotate_unit #(.DATA_W(64), .STAGES(1), .ADDR_W(AW)) dut1 (
    .clock(clock), .reset(reset), .in_valid(in_valid1), .in_op(op1),
    .ra_input(ra1), .rb_input(rb1), .I7_input(i7), .rt_address_input(rt_addr),
    .stall(stall), .flush(flush), .out_valid(o1_valid),
    .rt_value_output(o1_value), .rt_address_output(o1_addr),
    .wrt_en_output(o1_wen), .stage_valid(o1_sv), .stage_rt_address(o1_saddr)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Reference result straight from the operation definitions (128-bit datapath).
  function automatic logic [127:0] model_res(input sr_op_t op, input logic [127:0] a,
                                             input logic [127:0] b, input logic [6:0] im);
    logic [127:0] r;
    int bitc, bytec, n;
    bit imm;
    imm   = (op == SHLQBII) || (op == SHLQBYI) || (op == ROTQBII) || (op == ROTQBYI);
    bitc  = imm ? (int'(im) % 8)  : int'(b % 128'd8);
    bytec = imm ? (int'(im) % 32) : int'(b % 128'd32);
    r = '0;
    case (op)
      SHLQBI, SHLQBII: r = a << bitc;
      SHLQBY, SHLQBYI: if (bytec < 16) r = a << (8 * bytec);
      ROTQBI, ROTQBII, ROTQBY, ROTQBYI: begin
        n = (op == ROTQBI || op == ROTQBII) ? bitc : 8 * (bytec % 16);
        for (int i = 0; i < 128; i++) r[(i + n) % 128] = a[i];
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  typedef struct {
    logic [127:0] dat;
    logic [6:0]   addr;
    logic         wen;
    int           age;
  } exp_t;
  exp_t mq[$];

  // Each in-flight op ages by one on every non-stalled edge; it is the output at age ST.
  always @(posedge clock or negedge reset) begin
    if (!reset || flush) begin
      mq.delete();
    end else if (!stall) begin
      foreach (mq[i]) mq[i].age = mq[i].age + 1;
      while (mq.size() > 0 && mq[0].age > ST) void'(mq.pop_front());
      if (in_valid) mq.push_back('{model_res(in_op, ra, rb, i7), rt_addr, in_op != SR_NOP, 1});
    end
  end

  always @(negedge clock) begin : compare
    logic [ST-1:0] exp_sv;
    logic          exp_wen;
    exp_sv  = '0;
    exp_wen = 1'b0;
    foreach (mq[i]) begin
      if (mq[i].age >= 1 && mq[i].age <= ST) begin
        exp_sv[mq[i].age-1] = 1'b1;
        chk("m_stage_addr", 128'(stage_rt_address[(mq[i].age-1)*AW +: AW]), 128'(mq[i].addr));
      end
      if (mq[i].age == ST) begin
        chk("m_rt_value", rt_value_output, mq[i].dat);
        chk("m_rt_address", 128'(rt_address_output), 128'(mq[i].addr));
        exp_wen = mq[i].wen;
      end
    end
    chk("m_stage_valid", 128'(stage_valid), 128'(exp_sv));
    chk("m_out_valid", 128'(out_valid), 128'(exp_sv[ST-1]));
    chk("m_wrt_en", 128'(wrt_en_output), 128'(exp_wen));
    if (!reset) chk("m_reset_value", rt_value_output, 128'd0);
  end

  task automatic drive(input logic v, input sr_op_t op, input logic [127:0] a,
                       input logic [127:0] b, input logic [6:0] im, input logic [6:0] ad);
    in_valid = v; in_op = op; ra = a; rb = b; i7 = im; rt_addr = ad;
  endtask

  task automatic issue(input sr_op_t op, input logic [127:0] a, input logic [127:0] b,
                       input logic [6:0] im, input logic [6:0] ad);
    @(negedge clock);
    drive(1'b1, op, a, b, im, ad);
  endtask

  task automatic idle();
    @(negedge clock);
    drive(1'b0, SR_NOP, '0, '0, '0, '0);
  endtask

  task automatic after_edges(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  typedef struct {
    sr_op_t       op;
    logic [127:0] a;
    logic [127:0] b;
    logic [6:0]   im;
    logic [127:0] exp;
    logic         wen;
    string        name;
  } vec_t;
  vec_t tbl[$];

  // Issue the table back to back while collecting outputs in order.
  task automatic run_table();
    int j = 0;
    fork
      begin
        foreach (tbl[i]) issue(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].im, 7'(i + 20));
        idle();
      end
      begin
        for (int c = 0; c < 60 && j < tbl.size(); c++) begin
          @(negedge clock);
          #1;
          if (out_valid) begin
            chk(tbl[j].name, rt_value_output, tbl[j].exp);
            chk({tbl[j].name, "_wen"}, 128'(wrt_en_output), 128'(tbl[j].wen));
            chk({tbl[j].name, "_addr"}, 128'(rt_address_output), 128'(7'(j + 20)));
            j++;
          end
        end
      end
    join
    chk("table_count", 128'(j), 128'(tbl.size()));
  endtask

  int cnt;

  initial begin
    tbl.push_back('{SHLQBY,  128'd1, 128'd3, 7'd0, 128'h0100_0000, 1'b1, "shlqby_3"});
    tbl.push_back('{SHLQBY,  128'd1, 128'd16, 7'd0, 128'd0, 1'b1, "shlqby_16"});
    tbl.push_back('{ROTQBY,  128'hFF, 128'd17, 7'd0, 128'hFF00, 1'b1, "rotqby_17"});
    tbl.push_back('{SHLQBY,  128'd1, 128'd15, 7'd0,
                    128'h0100_0000_0000_0000_0000_0000_0000_0000, 1'b1, "shlqby_15"});
    tbl.push_back('{ROTQBI,  128'h8000_0000_0000_0000_0000_0000_0000_0001, 128'd1, 7'd0,
                    128'h3, 1'b1, "rotqbi_1"});
    tbl.push_back('{ROTQBII, 128'hF000_0000_0000_0000_0000_0000_0000_0000, 128'd0, 7'd4,
                    128'hF, 1'b1, "rotqbii_4"});
    tbl.push_back('{ROTQBYI, 128'hAB00_0000_0000_0000_0000_0000_0000_0000, 128'd0, 7'd33,
                    128'hAB, 1'b1, "rotqbyi_33"});
    tbl.push_back('{SHLQBYI, 128'h1234, 128'd0, 7'd16, 128'd0, 1'b1, "shlqbyi_16"});
    tbl.push_back('{SHLQBI,  128'd3, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFF9, 7'd0,
                    128'd6, 1'b1, "shlqbi_hi_rb"});
    tbl.push_back('{ROTQBY,  128'hDEAD_BEEF, 128'd0, 7'd0, 128'hDEAD_BEEF, 1'b1, "rotqby_0"});
    tbl.push_back('{SR_NOP,  128'd5, 128'd1, 7'd1, 128'd0, 1'b0, "nop"});

    // Reset state
    #1;
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_wrt_en", 128'(wrt_en_output), 128'd0);
    chk("rst_value", rt_value_output, 128'd0);
    chk("rst_stage_valid", 128'(stage_valid), 128'd0);
    chk("rst1_out_valid", 128'(o1_valid), 128'd0);
    chk("rst1_value", 128'(o1_value), 128'd0);
    @(negedge clock);
    reset = 1'b1;

    // Back-to-back SHLQBI then SHLQBII, latency 4
    issue(SHLQBI,  128'd20, 128'd10, 7'd0, 7'd5);
    issue(SHLQBII, 128'd15, 128'd0,  7'd5, 7'd6);
    idle();
    after_edges(2);
    chk("s1_valid", 128'(out_valid), 128'd1);
    chk("s1_value", rt_value_output, 128'd80);
    chk("s1_addr", 128'(rt_address_output), 128'd5);
    chk("s1_wen", 128'(wrt_en_output), 128'd1);
    after_edges(1);
    chk("s2_valid", 128'(out_valid), 128'd1);
    chk("s2_value", rt_value_output, 128'd480);
    chk("s2_addr", 128'(rt_address_output), 128'd6);
    after_edges(1);
    chk("s2_drain", 128'(out_valid), 128'd0);

    run_table();

    // Stall two cycles with three ops in flight
    issue(SHLQBI, 128'd1, 128'd1, 7'd0, 7'd1);
    issue(SHLQBI, 128'd1, 128'd2, 7'd0, 7'd2);
    issue(SHLQBI, 128'd1, 128'd3, 7'd0, 7'd3);
    @(negedge clock); in_valid = 1'b0; stall = 1'b1;
    chk("stall_sv0", 128'(stage_valid), 128'b0111);
    @(negedge clock); drive(1'b1, SHLQBI, 128'd1, 128'd7, 7'd0, 7'd9);
    chk("stall_sv1", 128'(stage_valid), 128'b0111);
    chk("stall_ov1", 128'(out_valid), 128'd0);
    @(negedge clock); in_valid = 1'b0; stall = 1'b0;
    chk("stall_sv2", 128'(stage_valid), 128'b0111);
    @(negedge clock);
    chk("stall_o1_valid", 128'(out_valid), 128'd1);
    chk("stall_o1_value", rt_value_output, 128'd2);
    chk("stall_o1_addr", 128'(rt_address_output), 128'd1);
    chk("stall_sv3", 128'(stage_valid), 128'b1110);
    @(negedge clock);
    chk("stall_o2_value", rt_value_output, 128'd4);
    @(negedge clock);
    chk("stall_o3_value", rt_value_output, 128'd8);
    chk("stall_o3_addr", 128'(rt_address_output), 128'd3);
    @(negedge clock);
    chk("stall_drain", 128'(out_valid), 128'd0);
    chk("stall_ignored_in", 128'(stage_valid), 128'd0);

    // Flush with a simultaneous 4th issue, plain and combined with stall
    for (int s = 0; s < 2; s++) begin
      issue(ROTQBI, 128'd5, 128'd1, 7'd0, 7'd1);
      issue(ROTQBI, 128'd5, 128'd2, 7'd0, 7'd2);
      issue(ROTQBI, 128'd5, 128'd3, 7'd0, 7'd3);
      @(negedge clock); drive(1'b1, ROTQBI, 128'd5, 128'd4, 7'd0, 7'd4);
      flush = 1'b1; stall = (s == 1);
      @(negedge clock); in_valid = 1'b0; flush = 1'b0; stall = 1'b0;
      chk("flush_sv", 128'(stage_valid), 128'd0);
      chk("flush_ov", 128'(out_valid), 128'd0);
      cnt = 0;
      repeat (8) begin
        @(negedge clock); #1;
        if (out_valid) cnt++;
      end
      chk("flush_quiet", 128'(cnt), 128'd0);
    end

    // Asynchronous reset with work in flight
    issue(SHLQBI, 128'd20, 128'd10, 7'd0, 7'd11);
    issue(SHLQBI, 128'd3,  128'd1,  7'd0, 7'd12);
    idle();
    after_edges(2);
    chk("prerst_valid", 128'(out_valid), 128'd1);
    chk("prerst_sv", 128'(stage_valid), 128'b1100);
    #1 reset = 1'b0;
    #1;
    chk("arst_valid", 128'(out_valid), 128'd0);
    chk("arst_wen", 128'(wrt_en_output), 128'd0);
    chk("arst_value", rt_value_output, 128'd0);
    chk("arst_addr", 128'(rt_address_output), 128'd0);
    chk("arst_sv", 128'(stage_valid), 128'd0);
    chk("arst_saddr", 128'(stage_rt_address), 128'd0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    drive(1'b1, SHLQBI, 128'd20, 128'd10, 7'd0, 7'd13);
    idle();
    after_edges(3);
    chk("post_rst_valid", 128'(out_valid), 128'd1);
    chk("post_rst_value", rt_value_output, 128'd80);
    chk("post_rst_addr", 128'(rt_address_output), 128'd13);

    // 64-bit, single-stage instance
    @(negedge clock); in_valid1 = 1'b1; op1 = SHLQBI; ra1 = 64'd20; rb1 = 64'd10;
    @(negedge clock); in_valid1 = 1'b0; op1 = SR_NOP;
    chk("w64_valid", 128'(o1_valid), 128'd1);
    chk("w64_value", 128'(o1_value), 128'd80);
    chk("w64_wen", 128'(o1_wen), 128'd1);
    @(negedge clock);
    chk("w64_drain", 128'(o1_valid), 128'd0);

    repeat (3) @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
